quotient_ascii_formatter: RTL and testbench

Downstream consumer of the fixed-point divider's result. Accepts one integer quotient (SIZE bits) plus a 3-digit decimal fraction code (0..999) per transaction. Converts them to decimal digits by sequential repeated subtraction. Streams the result as ASCII characters, e.g. "3.333", over a valid/ready byte interface toward a UART/display stage.

---
 rtl/quotient_fmt_pkg.sv | 27 ++
 rtl/digit_extract.sv | 45 ++++
 rtl/quotient_ascii_formatter.sv | 203 ++++++++++++++++++++
 tb/tb_quotient_ascii_formatter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/quotient_fmt_pkg.sv
// Shared encodings, ASCII constants and divisor helper for the quotient formatter.
package quotient_fmt_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned FRAC_W   = 10;
  localparam int unsigned FRAC_MAX = 999;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [7:0] ZERO_CH = 8'h30;
  localparam logic [7:0] DOT_CH  = 8'h2E;
  localparam logic [7:0] E_CH    = 8'h45;
  localparam logic [7:0] R_CH    = 8'h52;

  // 10^n for n in 0..9; fixed trip count keeps it synthesizable with a variable n.
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < n) r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_extract.sv
// Repeated-subtraction decimal digit unit, shared across all digit positions.
import quotient_fmt_pkg::*;

module digit_extract #(
  parameter int unsigned W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_start,
  input  logic [W-1:0]       i_residue,
  input  logic [W-1:0]       i_divisor,
  output logic [DIGIT_W-1:0] o_digit_c,
  output logic [W-1:0]       o_remainder_c,
  output logic               o_done_c
);

  logic [W-1:0]       r_res;
  logic [DIGIT_W-1:0] r_digit;
  logic [W-1:0]       w_res;
  logic [DIGIT_W-1:0] w_digit;
  logic               w_ge;

  // A start cycle restarts from the new residue with a zero digit; done when no subtract is possible.
  always_comb begin
    w_res         = i_start ? i_residue : r_res;
    w_digit       = i_start ? '0 : r_digit;
    w_ge          = (w_res >= i_divisor);
    o_digit_c     = w_digit;
    o_remainder_c = w_res;
    o_done_c      = i_en & ~w_ge;
  end

  // One subtraction per cycle while the residue still covers the divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res   <= '0;
      r_digit <= '0;
    end else if (i_en && w_ge) begin
      r_res   <= w_res - i_divisor;
      r_digit <= w_digit + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/quotient_ascii_formatter.sv
// Converts a divider result (integer + 3-digit fraction) to an ASCII byte stream.
import quotient_fmt_pkg::*;

module quotient_ascii_formatter #(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned INT_DIGITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_int,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned NPOS  = INT_DIGITS + 3;
  localparam int unsigned NSLOT = INT_DIGITS + 4;
  localparam int unsigned IW    = $clog2(NSLOT);
  localparam int unsigned BW    = $clog2(NPOS);
  localparam int unsigned DW    = (SIZE > FRAC_W) ? SIZE : FRAC_W;

  logic [1:0]         r_state, w_state_nxt;
  logic               r_err, w_err_nxt;
  logic [FRAC_W-1:0]  r_frac, w_frac_nxt;
  logic [DW-1:0]      r_carry, w_carry_nxt;
  logic [BW-1:0]      r_pos, w_pos_nxt;
  logic               r_start, w_start_nxt;
  logic [DIGIT_W-1:0] r_buf [NPOS];
  logic [DIGIT_W-1:0] w_buf_nxt [NPOS];
  logic [IW-1:0]      r_idx, w_idx_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [7:0]         r_out_data, w_out_data_nxt;
  logic               r_out_last, w_out_last_nxt;
  logic               r_in_ready, w_in_ready_nxt;
  logic               r_busy, w_busy_nxt;

  int unsigned        w_pos_u;
  logic [DW-1:0]      w_divisor;
  logic [DIGIT_W-1:0] w_digit;
  logic [DW-1:0]      w_rem;
  logic               w_done;
  logic [IW-1:0]      w_first_idx;
  logic [IW-1:0]      w_idx_m1;
  logic [7:0]         w_char;
  logic               w_last;
  logic               w_bad;

  digit_extract #(.W(DW)) u_digit (
    .clk           (clk),
    .rst           (rst),
    .i_en          (r_state == S_CONV),
    .i_start       (r_start),
    .i_residue     (r_carry),
    .i_divisor     (w_divisor),
    .o_digit_c     (w_digit),
    .o_remainder_c (w_rem),
    .o_done_c      (w_done)
  );

  // Divisor for the current position: integer powers first, then 100/10/1 on the fraction.
  always_comb begin
    w_pos_u = 32'(r_pos);
    if (w_pos_u < INT_DIGITS) w_divisor = DW'(pow10(INT_DIGITS - 1 - w_pos_u));
    else                      w_divisor = DW'(pow10(NPOS - 1 - w_pos_u));
  end

  // Leading-zero skip: first nonzero integer digit, else the units digit.
  always_comb begin
    w_first_idx = IW'(INT_DIGITS - 1);
    for (int i = int'(INT_DIGITS) - 1; i >= 0; i--) begin
      if (r_buf[BW'(i)] != '0) w_first_idx = IW'(i);
    end
  end

  // Character for the current emit slot; the dot occupies slot INT_DIGITS.
  always_comb begin
    w_idx_m1 = r_idx - IW'(1);
    w_char   = 8'h00;
    w_last   = 1'b0;
    if (r_err) begin
      w_char = (r_idx == '0) ? E_CH : R_CH;
      w_last = (r_idx == IW'(2));
    end else if (32'(r_idx) < INT_DIGITS) begin
      w_char = ZERO_CH + 8'(r_buf[BW'(r_idx)]);
    end else if (32'(r_idx) == INT_DIGITS) begin
      w_char = DOT_CH;
    end else begin
      w_char = ZERO_CH + 8'(r_buf[BW'(w_idx_m1)]);
      w_last = (32'(r_idx) == NSLOT - 1);
    end
  end

  assign w_bad = in_err || (in_frac > FRAC_W'(FRAC_MAX));

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_err_nxt       = r_err;
    w_frac_nxt      = r_frac;
    w_carry_nxt     = r_carry;
    w_pos_nxt       = r_pos;
    w_start_nxt     = 1'b0;
    w_buf_nxt       = r_buf;
    w_idx_nxt       = r_idx;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_err_nxt   = w_bad;
          w_frac_nxt  = in_frac;
          w_carry_nxt = DW'(in_int);
          w_pos_nxt   = '0;
          w_idx_nxt   = '0;
          w_start_nxt = 1'b1;
          w_state_nxt = w_bad ? S_EMIT : S_CONV;
        end
      end
      S_CONV: begin
        if (w_done) begin
          w_buf_nxt[r_pos] = w_digit;
          if (32'(r_pos) == NPOS - 1) begin
            w_state_nxt = S_EMIT;
            w_idx_nxt   = w_first_idx;
          end else begin
            w_pos_nxt   = r_pos + BW'(1);
            w_start_nxt = 1'b1;
            w_carry_nxt = (32'(r_pos) == INT_DIGITS - 1) ? DW'(r_frac) : w_rem;
          end
        end
      end
      S_EMIT: begin
        if (!r_out_valid) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = w_char;
          w_out_last_nxt  = w_last;
          w_idx_nxt       = r_idx + IW'(1);
        end else if (out_ready) begin
          if (r_out_last) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = 8'h00;
            w_out_last_nxt  = 1'b0;
          end else begin
            w_out_data_nxt  = w_char;
            w_out_last_nxt  = w_last;
            w_idx_nxt       = r_idx + IW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_in_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt     = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_err       <= 1'b0;
      r_frac      <= '0;
      r_carry     <= '0;
      r_pos       <= '0;
      r_start     <= 1'b0;
      r_buf       <= '{default: '0};
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_err       <= w_err_nxt;
      r_frac      <= w_frac_nxt;
      r_carry     <= w_carry_nxt;
      r_pos       <= w_pos_nxt;
      r_start     <= w_start_nxt;
      r_buf       <= w_buf_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule

// File: tb/tb_quotient_ascii_formatter.sv
// Directed bench for quotient_ascii_formatter (SIZE=4, INT_DIGITS=2).
module tb_quotient_ascii_formatter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_int;
  logic [9:0] in_frac;
  logic       in_err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  quotient_ascii_formatter #(.SIZE(4), .INT_DIGITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_int    (in_int),
    .in_frac   (in_frac),
    .in_err    (in_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a transaction and wait (bounded) for it to be accepted.
  task automatic send(input logic [3:0] vi, input logic [9:0] vf, input logic ve);
    int w;
    w = 0;
    @(negedge clk);
    in_int = vi; in_frac = vf; in_err = ve; in_valid = 1'b1;
    while (!in_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("send_accept_timeout", 32'(w < 2000), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge to the edge that raises out_valid.
  task automatic measure(input string tag, input int exp);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid && lat < 300);
    chk(tag, 32'(lat), 32'(exp));
  endtask

  // Collect a string; optional out_ready pattern 1,0,0,1,0,0...
  task automatic recv(input string tag, input string s, input bit stall);
    int n, cyc, k;
    n = 0; cyc = 0; k = 0;
    while (n < s.len() && cyc < 500) begin
      @(negedge clk);
      cyc++;
      out_ready = stall ? ((k % 3) == 0) : 1'b1;
      k++;
      if (stall) chk({tag, "_in_ready_low"}, 32'(in_ready), 32'(0));
      if (out_valid) begin
        chk({tag, "_data"}, 32'(out_data), 32'(s[n]));
        if (out_ready) begin
          chk({tag, "_last"}, 32'(out_last), 32'(n == s.len() - 1));
          n++;
        end
      end
    end
    chk({tag, "_count"}, 32'(n), 32'(s.len()));
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_data"}, 32'(out_data), 32'(0));
    chk({tag, "_out_last"}, 32'(out_last), 32'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_int = '0; in_frac = '0; in_err = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_values("reset");
    rst = 1'b0;

    // 3.333: digits 0,3,3,3,3 -> 1+(1+4+4+4+4) = 18
    send(4'd3, 10'd333, 1'b0);
    chk("conv_busy", 32'(busy), 32'(1));
    measure("lat_3_333", 18);
    recv("s_3_333", "3.333", 1'b0);
    idle_check("after_3_333");

    // 0.000: all zero digits -> 1+5 = 6
    send(4'd0, 10'd0, 1'b0);
    measure("lat_0_000", 6);
    recv("s_0_000", "0.000", 1'b0);
    idle_check("after_0_000");

    // Error flag -> ERR, one cycle latency
    send(4'd7, 10'd123, 1'b1);
    measure("lat_err", 1);
    recv("s_err", "ERR", 1'b0);
    idle_check("after_err");

    // Fraction out of range -> ERR
    send(4'd0, 10'd1000, 1'b0);
    measure("lat_frac1000", 1);
    recv("s_frac1000", "ERR", 1'b0);
    idle_check("after_frac1000");

    // Stalled 3.333 with the next offer held on in_valid throughout
    send(4'd3, 10'd333, 1'b0);
    in_int = 4'd15; in_frac = 10'd5; in_err = 1'b0; in_valid = 1'b1;
    measure("lat_stall", 18);
    recv("s_stall", "3.333", 1'b1);
    @(negedge clk);
    chk("held_in_ready_rise", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("held_accepted_busy", 32'(busy), 32'(1));
    // 15.005: digits 1,5,0,0,5 -> 1+(2+6+1+1+6) = 17
    measure("lat_15_005", 17);
    recv("s_15_005", "15.005", 1'b0);
    idle_check("after_15_005");

    // Reset mid-conversion
    send(4'd3, 10'd333, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_conv_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    reset_values("rst_conv");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-emit while stalled
    out_ready = 1'b0;
    send(4'd15, 10'd5, 1'b0);
    measure("lat_rst_emit", 17);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_emit_valid", 32'(out_valid), 32'(1));
    chk("pre_rst_emit_data", 32'(out_data), 32'(8'h31));
    rst = 1'b1;
    #1;
    reset_values("rst_emit");
    @(negedge clk);
    rst = 1'b0;

    // Clean transaction after reset: 2.500 -> digits 0,2,5,0,0 -> 1+(1+3+6+1+1) = 13
    send(4'd2, 10'd500, 1'b0);
    measure("lat_2_500", 13);
    recv("s_2_500", "2.500", 1'b0);
    idle_check("after_2_500");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
